// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and helpers for the MIPS fetch path
// Purpose: default fetch-window bounds, the reset PC and the nop encoding,
// plus the fetch-legality helper used by the PC register.
// Ports: none (package).
package mips_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] IM_LIMIT_DEFAULT = 32'h0000_6FFF;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    // A fetch is legal only when word aligned and inside [base, limit].
    function automatic logic fetch_legal(input logic [31:0] pc,
                                         input logic [31:0] base,
                                         input logic [31:0] limit);
        return (pc >= base) && (pc <= limit) && (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with next-PC mux and fetch legality check
// Purpose: holds the fetch PC and selects the next PC with priority
// reset > stall > redirect > sequential (+4, 32-bit wrap).
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   stall             - hold the PC
//   redirect          - load redirect_pc instead of PC + 4
//   redirect_pc[31:0] - branch/jump target (not range checked here)
//   pc_o[31:0]        - current fetch address (register output)
//   illegal_o         - current fetch address is out of range or misaligned
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
    parameter logic [31:0] IM_LIMIT = IM_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_o,
    output logic        illegal_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            if (redirect) begin
                pc_d = redirect_pc;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o      = pc_q;
    assign illegal_o = !fetch_legal(pc_q, IM_BASE, IM_LIMIT);

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - instruction fetch stage and IF/ID pipeline register
// Purpose: drives the instruction-memory address and latches the fetched word,
// its PC and a fetch-error flag into decode. Redirects use delay-slot
// semantics, so the word fetched on the redirect edge is latched normally.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   stall             - freeze PC and IF/ID register
//   redirect          - decode-stage branch taken / jump
//   redirect_pc[31:0] - redirect target
//   F_pc[31:0]        - fetch address to instruction memory
//   F_instr[31:0]     - instruction memory read data for F_pc
//   D_instr[31:0]     - latched instruction (nop on illegal fetch)
//   D_pc[31:0]        - PC of D_instr
//   D_pc8[31:0]       - D_pc + 8 link address
//   D_imm16[15:0]     - D_instr[15:0] for the immediate extender
//   D_fetch_err       - latched word came from an illegal address
module if_id_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
    parameter logic [31:0] IM_LIMIT = IM_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] F_pc,
    input  logic [31:0] F_instr,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic [31:0] D_pc8,
    output logic [15:0] D_imm16,
    output logic        D_fetch_err
);

    logic        f_illegal;
    logic [31:0] d_instr_q, d_instr_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic        d_err_q, d_err_d;

    pc_reg #(
        .PC_RESET (PC_RESET),
        .IM_BASE  (IM_BASE),
        .IM_LIMIT (IM_LIMIT)
    ) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc_o        (F_pc),
        .illegal_o   (f_illegal)
    );

    // Redirect does not gate this path: the word at F_pc is the delay slot.
    always_comb begin
        d_instr_d = d_instr_q;
        d_pc_d    = d_pc_q;
        d_err_d   = d_err_q;
        if (!stall) begin
            d_instr_d = f_illegal ? NOP : F_instr;
            d_pc_d    = F_pc;
            d_err_d   = f_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_instr_q <= NOP;
            d_pc_q    <= 32'd0;
            d_err_q   <= 1'b0;
        end else begin
            d_instr_q <= d_instr_d;
            d_pc_q    <= d_pc_d;
            d_err_q   <= d_err_d;
        end
    end

    assign D_instr     = d_instr_q;
    assign D_pc        = d_pc_q;
    assign D_pc8       = d_pc_q + 32'd8;
    assign D_imm16     = d_instr_q[15:0];
    assign D_fetch_err = d_err_q;

endmodule
